// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the two-port memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mem_op_t;

    function automatic int OFFSET_BITS(input int block_w);
        return $clog2(block_w / 8);
    endfunction

endpackage

// File: rtl/arb_rr_select.sv
// rtl/arb_rr_select.sv - combinational two-way winner picker with round-robin tie break
module arb_rr_select #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] active,
    input  logic       last_grant,
    output logic       win_valid,
    output logic       win_id
);

    always_comb begin
        win_valid = |active;
        win_id    = 1'b0;
        if (active == 2'b10) begin
            win_id = 1'b1;
        end else if (active == 2'b11) begin
            // On a tie the requester that did not win last time goes next.
            win_id = FIXED_PRIO ? 1'b0 : ~last_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - grants the shared main-memory block port to one of two cache controllers
module mem_arbiter #(
    parameter int BLOCK_W    = 128,
    parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_rd,
    input  logic [1:0]             req_wr,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][BLOCK_W-1:0] req_wdata,
    output logic [1:0]             rsp_ready,
    output logic [BLOCK_W-1:0]     rsp_rdata,
    output logic                   mem_read_en,
    output logic                   mem_write_en,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [BLOCK_W-1:0]     mem_wdata,
    input  logic [BLOCK_W-1:0]     mem_rdata,
    input  logic                   mem_ready,
    output logic                   grant_id
);
    import mem_arb_pkg::*;

    localparam int OFF_W = OFFSET_BITS(BLOCK_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    arb_state_t         state, state_n;
    mem_op_t            op, op_n;
    logic               last_grant, last_grant_n;
    logic               grant_id_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [BLOCK_W-1:0] wdata_n, rdata_n;
    logic               rd_en_n, wr_en_n;
    logic [1:0]         rsp_ready_n;
    logic               win_valid, win_id;

    arb_rr_select #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_select (
        .active     (req_rd | req_wr),
        .last_grant (last_grant),
        .win_valid  (win_valid),
        .win_id     (win_id)
    );

    always_comb begin
        state_n      = state;
        op_n         = op;
        last_grant_n = last_grant;
        grant_id_n   = grant_id;
        addr_n       = mem_addr;
        wdata_n      = mem_wdata;
        rdata_n      = rsp_rdata;
        rd_en_n      = 1'b0;
        wr_en_n      = 1'b0;
        rsp_ready_n  = 2'b00;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    // A pending write-back goes before a refill from the same requester.
                    op_n       = req_wr[win_id] ? OP_WR : OP_RD;
                    grant_id_n = win_id;
                    addr_n     = req_addr[win_id] & ALIGN_MASK;
                    wdata_n    = req_wdata[win_id];
                    rd_en_n    = ~req_wr[win_id];
                    wr_en_n    = req_wr[win_id];
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (op == OP_RD) begin
                        rdata_n = mem_rdata;
                    end
                    last_grant_n          = grant_id;
                    rsp_ready_n[grant_id] = 1'b1;
                    state_n               = RESP;
                end else begin
                    rd_en_n = (op == OP_RD);
                    wr_en_n = (op == OP_WR);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op           <= OP_RD;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rsp_rdata    <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            rsp_ready    <= 2'b00;
        end else begin
            state        <= state_n;
            op           <= op_n;
            last_grant   <= last_grant_n;
            grant_id     <= grant_id_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
            rsp_rdata    <= rdata_n;
            mem_read_en  <= rd_en_n;
            mem_write_en <= wr_en_n;
            rsp_ready    <= rsp_ready_n;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single main-memory block port between two cache controllers, requester 0 (data cache) and requester 1 (instruction cache). Each requester issues block refills (read) and dirty-block write-backs (write). The arbiter grants one transaction at a time, holds the memory enables for that transaction until memory completes, returns read data and a one-cycle ready pulse to the winner, and alternates priority round-robin. It sits between the cache controllers and `main_memory`.

## Interface
- `BLOCK_W`, 128: block width in bits, equal to `` `BLOCK_SIZE ``.
- `ADDR_W`, 32: byte address width.
- `FIXED_PRIO`, 0: if 1, requester 0 always wins ties and the round-robin pointer is ignored.

- `clk`  in  1  clock; one clock domain; synchronous active-high reset.
- `rst`  in  1  synchronous, active-high reset.
- `req_rd[1:0]`  in  2  per-requester block-read request; level, held until that requester's `rsp_ready`.
- `req_wr[1:0]`  in  2  per-requester block-write (write-back) request; level, held until `rsp_ready`.
- `req_addr[1:0]`  in  2×ADDR_W  per-requester byte address.
- `req_wdata[1:0]`  in  2×BLOCK_W  per-requester write block.
- `rsp_ready[1:0]`  out  2  one-cycle completion pulse to the granted requester.
- `rsp_rdata`  out  BLOCK_W  read block, valid while `rsp_ready` is high; otherwise holds its last value.
- `mem_read_en`  out  1  to memory `read_en_mem`.
- `mem_write_en`  out  1  to memory `write_en_mem`.
- `mem_addr`  out  ADDR_W  block-aligned address to memory.
- `mem_wdata`  out  BLOCK_W  to memory `dirty_block_in`.
- `mem_rdata`  in  BLOCK_W  from memory `block_out`.
- `mem_ready`  in  1  from memory `ready_mem`; a one-cycle done pulse.
- `grant_id`  out  1  index of the current or last granted requester; observability output.

## Operation
- FSM states are `IDLE`, `BUSY`, and `RESP`.
- In `IDLE`:
  - A requester is active if its `req_rd` or `req_wr` is high.
  - If none is active, stay in `IDLE`.
  - Otherwise pick a winner. With one active requester, it wins. With both active, the requester not equal to `last_grant` wins (or requester 0 if `FIXED_PRIO`=1).
  - Latch the winner's op, address, and write data; set `grant_id`; go to `BUSY`.
- Op selection: if the winner has both `req_rd` and `req_wr` high, the write is taken first. The read remains pending and is arbitrated later like any new request.
- In `BUSY`:
  - Exactly one of `mem_read_en`/`mem_write_en` is high, driven from the latched op.
  - `mem_addr` and `mem_wdata` are driven from the latched values and stay stable.
  - Requester inputs are ignored.
  - On `mem_ready`: capture `mem_rdata` into `rsp_rdata` (reads only; writes leave it unchanged), set `last_grant` to `grant_id`, and go to `RESP`.
- In `RESP`: assert `rsp_ready[grant_id]` for exactly one cycle with both mem enables low, then go to `IDLE`.
- Address alignment: `mem_addr` is the latched address with its low $clog2(BLOCK_W/8) bits forced to 0 (4 bits at defaults).
- `mem_ready` arriving in `IDLE` or `RESP` is ignored.
- Requester contract: the requester drops `req_*` at the clock edge that ends its `rsp_ready` cycle. The following `IDLE` cycle therefore sees no stale request.

## Timing
- Reset values (all outputs): `mem_read_en`=0, `mem_write_en`=0, `mem_addr`=0, `mem_wdata`=0, `rsp_ready`=0, `rsp_rdata`=0, `grant_id`=0.
- Internal reset: `last_grant`=1, so requester 0 wins the first tie. State returns to `IDLE`.
- All outputs are registered; there are no combinational input-to-output paths.
- Cycle sequence:
  - Request seen in `IDLE` in cycle t: mem enables are high from t+1.
  - `mem_ready` in cycle k: `rsp_ready` pulses in k+1, state is `IDLE` in k+2, and the next grant's enables rise at k+3 at the earliest.
- Minimum turnaround between back-to-back transactions: 2 cycles with enables low.
- Reset mid-`BUSY` or mid-`RESP`: the transaction is dropped with no `rsp_ready`. Enables are low in the cycle after the reset edge. Memory is reset by the same `rst`.
- Fairness: with both requesters continuously active and `FIXED_PRIO`=0, grants strictly alternate 0,1,0,1.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` (`IDLE`/`BUSY`/`RESP`);
  - the op enum `mem_op_t` (`OP_RD`/`OP_WR`);
  - `ADDR_W`;
  - an `OFFSET_BITS(BLOCK_W)` function.
- Sub-module `arb_rr_select` is the combinational 2-way picker.
  - Inputs: `active[1:0]`, `last_grant`, `FIXED_PRIO`.
  - Outputs: `win_valid`, `win_id`.
- Top `mem_arbiter` holds the FSM, the latch registers, and output registers.

## Test plan
- Single read: requester 0 reads at 0x0000_1234; memory returns 0xDEAD…BEEF after 5 cycles. Expect `mem_addr`=0x0000_1230, `mem_read_en` high for exactly 5 cycles, then `rsp_ready`=2'b01 for one cycle with `rsp_rdata`=0xDEAD…BEEF.
- Tie after reset: both read in the same cycle. Expect requester 0 granted first, then requester 1. `grant_id` sequence is 0,1; `rsp_ready` sequence is 01 then 10.
- Continuous contention: both requesters hold requests for 6 transactions. Expect grants 0,1,0,1,0,1. With `FIXED_PRIO`=1, expect all grants to requester 0 until it idles.
- Rd+wr together: requester 1 asserts both at 0x80 with wdata=0xA5…A5. Expect the write first (`mem_write_en`, `mem_wdata`=0xA5…A5), then the read. `rsp_rdata` is unchanged after the write.
- Stray ready: `mem_ready` pulsed in `IDLE` and in `RESP`. Expect no state change and no extra `rsp_ready`.
- Reset mid-`BUSY`: `rst` asserted on the 3rd cycle of `BUSY`. Expect enables 0 the next cycle, no `rsp_ready`, and the next tie won by requester 0.
